// File: rtl/bw_io_cmos2_pad_bank.sv
// bw_io_cmos2_pad_bank: POR-gated CMOS2 pad drivers with synchronised, glitch-filtered receivers
module bw_io_cmos2_pad_bank #(
  parameter int NCH      = 4,
  parameter int FILT_LEN = 4,
  parameter int POR_DLY  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           por_l,
  input  logic [NCH-1:0] oe,
  input  logic [NCH-1:0] data,
  input  logic [NCH-1:0] od_mode,
  input  logic [NCH-1:0] filt_en,
  input  logic [NCH-1:0] pad_in,
  output logic [NCH-1:0] pad_out,
  output logic [NCH-1:0] pad_oe,
  output logic [NCH-1:0] to_core,
  output logic [NCH-1:0] chg,
  output logic           ready
);
  localparam int DW = POR_DLY > 1 ? $clog2(POR_DLY) : 1;
  localparam int FW = FILT_LEN > 1 ? $clog2(FILT_LEN) : 1;
  localparam logic [DW-1:0] DLY_MAX = DW'(POR_DLY - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_ACTIVE} state_t;
  state_t state;
  logic [DW-1:0] dly;
  logic [NCH-1:0] s1, s2;
  logic [FW-1:0] fcnt [NCH];
  assign ready = state == S_ACTIVE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_HOLD;
      dly     <= '0;
      pad_oe  <= '0;
      pad_out <= '0;
    end else begin
      if (!por_l) state <= S_HOLD;
      else if (state == S_HOLD) begin
        state <= S_WAIT;
        dly   <= '0;
      end else if (state == S_WAIT) begin
        if (dly == DLY_MAX) state <= S_ACTIVE;
        else dly <= dly + 1'b1;
      end
      pad_oe  <= ready ? oe & ~(od_mode & data) : '0;
      pad_out <= ready ? data & ~od_mode : '0;
    end
  end
  // a differing sample either commits immediately (bypass) or after FILT_LEN in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      to_core <= '0;
      chg     <= '0;
      for (int i = 0; i < NCH; i++) fcnt[i] <= '0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
      for (int i = 0; i < NCH; i++) begin
        chg[i]  <= 1'b0;
        fcnt[i] <= '0;
        if (s2[i] != to_core[i]) begin
          if (!filt_en[i] || fcnt[i] == FILT_MAX) begin
            to_core[i] <= s2[i];
            chg[i]     <= 1'b1;
          end else fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end
endmodule
